// File: rtl/sl_receiver_fifo.sv
// Two-wire SL frame receiver with parity/length/level checks and a DEPTH-entry receive FIFO.
// Optional macro: SL_RX_GLITCH_FILTER_EN adds a 3-sample glitch filter on both synced lines.
module sl_receiver_fifo #(
    parameter int MAX_LEN  = 32,
    parameter int DEPTH    = 4,
    parameter int LEVEL_TO = 1024,
    localparam int LW  = $clog2(MAX_LEN + 1),
    localparam int FLW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               serial_line_zeroes_a,
    input  logic               serial_line_ones_a,
    input  logic               cfg_wr,
    input  logic [LW-1:0]      cfg_len,
    input  logic               cfg_pce,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MAX_LEN-1:0] out_data,
    output logic [7:0]         out_status,
    output logic [FLW-1:0]     fifo_level
);
    localparam int CW = $clog2(MAX_LEN + 3);
    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(LEVEL_TO + 1);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(MAX_LEN + 2);
    localparam logic [TW-1:0]  LVL_LAST = TW'(LEVEL_TO - 1);
    localparam logic [TW-1:0]  LVL_MAX  = TW'(LEVEL_TO);
    localparam logic [FLW-1:0] LVL_FULL = FLW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RX, ST_ABORT} state_t;

    // bit 0 = zeroes line, bit 1 = ones line
    logic [1:0] meta_q, sync_q, line_s, low_s;
    logic       any_low_s;

    state_t              state_q, state_d;
    logic                in_sym_q, in_sym_d;
    logic [1:0]          mask_q, mask_d;
    logic [CW-1:0]       count_q, count_d;
    logic [MAX_LEN-1:0]  data_q, data_d;
    logic                par_q, par_d;
    logic [LW-1:0]       act_len_q, act_len_d, sh_len_q, sh_len_d, len_s;
    logic                act_pce_q, act_pce_d, sh_pce_q, sh_pce_d, pce_s;
    logic [TW-1:0]       low_cnt_q, low_cnt_d;
    logic                push_q, push_d;
    logic [MAX_LEN-1:0]  push_data_q, push_data_d;
    logic [7:0]          push_status_q, push_status_d;
    logic [CW-1:0]       cnt_s, exp_cnt_s;
    logic                len_err_s, sym_bit_s;

    logic [MAX_LEN-1:0]  mem_data_q [DEPTH];
    logic [7:0]          mem_stat_q [DEPTH];
    logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [FLW-1:0]      level_q, level_d;
    logic                ovf_q, ovf_d, pop_s, accept_s;

    // Two-flop synchronisers, idle-high reset value
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= {serial_line_ones_a, serial_line_zeroes_a};
            sync_q <= meta_q;
        end
    end

`ifdef SL_RX_GLITCH_FILTER_EN
    logic [1:0] h1_q, h2_q, filt_q;

    // A line only changes once three consecutive synced samples agree
    always_comb begin
        line_s = filt_q;
        for (int i = 0; i < 2; i++) begin
            if ((sync_q[i] == h1_q[i]) && (h1_q[i] == h2_q[i])) line_s[i] = sync_q[i];
            else                                                line_s[i] = filt_q[i];
        end
    end

    // Filter sample history and held level
    always_ff @(posedge clk) begin
        if (rst) begin
            h1_q   <= 2'b11;
            h2_q   <= 2'b11;
            filt_q <= 2'b11;
        end else begin
            h1_q   <= sync_q;
            h2_q   <= h1_q;
            filt_q <= line_s;
        end
    end
`else
    assign line_s = sync_q;
`endif

    assign low_s     = ~line_s;
    assign any_low_s = |low_s;

    // Symbol/frame decoder and level-error detector; produces at most one push per cycle
    always_comb begin
        state_d       = state_q;
        in_sym_d      = in_sym_q;
        mask_d        = mask_q;
        count_d       = count_q;
        data_d        = data_q;
        par_d         = par_q;
        act_len_d     = act_len_q;
        act_pce_d     = act_pce_q;
        low_cnt_d     = low_cnt_q;
        push_d        = 1'b0;
        push_data_d   = '0;
        push_status_d = 8'h00;
        sym_bit_s     = mask_q[1];
        if (cfg_wr) begin
            sh_len_d = cfg_len;
            sh_pce_d = cfg_pce;
        end else begin
            sh_len_d = sh_len_q;
            sh_pce_d = sh_pce_q;
        end
        // The first symbol of a frame is judged against the shadow config it latches
        if (state_q == ST_IDLE) begin
            len_s = sh_len_q;
            pce_s = sh_pce_q;
            cnt_s = '0;
        end else begin
            len_s = act_len_q;
            pce_s = act_pce_q;
            cnt_s = count_q;
        end
        exp_cnt_s = CW'(len_s) + CW'(pce_s);
        len_err_s = (state_q == ST_IDLE) || (cnt_s != exp_cnt_s);

        if (any_low_s) begin
            in_sym_d = 1'b1;
            mask_d   = mask_q | low_s;
            if (low_cnt_q != LVL_MAX) low_cnt_d = low_cnt_q + TW'(1);
            else                      low_cnt_d = low_cnt_q;
            if ((low_cnt_q == LVL_LAST) && (state_q != ST_ABORT)) begin
                push_d        = 1'b1;
                push_data_d   = data_q;
                push_status_d = 8'h20;
                state_d       = ST_ABORT;
            end else begin
                state_d = state_q;
            end
        end else begin
            low_cnt_d = '0;
            in_sym_d  = 1'b0;
            mask_d    = 2'b00;
            if (state_q == ST_ABORT) begin
                state_d = ST_IDLE;
                count_d = '0;
                data_d  = '0;
                par_d   = 1'b0;
            end else if (in_sym_q) begin
                case (mask_q)
                    2'b11: begin
                        push_d        = 1'b1;
                        push_data_d   = data_q;
                        push_status_d = {3'b000, pce_s & ~len_err_s & ~par_q, 1'b1, 2'b00, len_err_s};
                        state_d       = ST_IDLE;
                        count_d       = '0;
                        data_d        = '0;
                        par_d         = 1'b0;
                    end
                    2'b01, 2'b10: begin
                        state_d   = ST_RX;
                        act_len_d = len_s;
                        act_pce_d = pce_s;
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if ((cnt_s < CW'(len_s)) && (CW'(i) == cnt_s)) data_d[i] = sym_bit_s;
                            else                                           data_d[i] = data_q[i];
                        end
                        if (cnt_s < exp_cnt_s) par_d = par_q ^ sym_bit_s;
                        else                   par_d = par_q;
                        if (cnt_s == CNT_SAT) count_d = cnt_s;
                        else                  count_d = cnt_s + CW'(1);
                    end
                    default: state_d = state_q;
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    // Decoder state, shadow/active config and the registered push request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_sym_q      <= 1'b0;
            mask_q        <= 2'b00;
            count_q       <= '0;
            data_q        <= '0;
            par_q         <= 1'b0;
            act_len_q     <= LW'(MAX_LEN);
            act_pce_q     <= 1'b0;
            sh_len_q      <= LW'(MAX_LEN);
            sh_pce_q      <= 1'b0;
            low_cnt_q     <= '0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            push_status_q <= 8'h00;
        end else begin
            state_q       <= state_d;
            in_sym_q      <= in_sym_d;
            mask_q        <= mask_d;
            count_q       <= count_d;
            data_q        <= data_d;
            par_q         <= par_d;
            act_len_q     <= act_len_d;
            act_pce_q     <= act_pce_d;
            sh_len_q      <= sh_len_d;
            sh_pce_q      <= sh_pce_d;
            low_cnt_q     <= low_cnt_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            push_status_q <= push_status_d;
        end
    end

    assign out_valid  = (level_q != '0);
    assign pop_s      = out_valid & out_ready;
    // A simultaneous pop frees the slot, so a push into a full FIFO is not dropped then
    assign accept_s   = push_q & ((level_q != LVL_FULL) | pop_s);
    assign out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
    assign out_status = out_valid ? mem_stat_q[rd_ptr_q] : 8'h00;
    assign fifo_level = level_q;

    // FIFO occupancy and sticky overflow
    always_comb begin
        case ({accept_s, pop_s})
            2'b10:   level_d = level_q + FLW'(1);
            2'b01:   level_d = level_q - FLW'(1);
            default: level_d = level_q;
        endcase
        if (accept_s)    ovf_d = 1'b0;
        else if (push_q) ovf_d = 1'b1;
        else             ovf_d = ovf_q;
    end

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_stat_q[i] <= 8'h00;
            end
        end else begin
            if (accept_s) begin
                mem_data_q[wr_ptr_q] <= push_data_q;
                mem_stat_q[wr_ptr_q] <= push_status_q | {1'b0, ovf_q, 6'b000000};
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_sl_receiver_fifo.sv
// Self-checking bench for sl_receiver_fifo: vector table, corner sequences and randomized frames vs. a frame-level model.
module tb_sl_receiver_fifo;
    localparam int MAX_LEN  = 32;
    localparam int DEPTH    = 4;
    localparam int LEVEL_TO = 1024;

    logic        clk = 1'b0, rst = 1'b1;
    logic        zl = 1'b1, ol = 1'b1;
    logic        cfg_wr = 1'b0, cfg_pce = 1'b0, out_ready = 1'b0;
    logic [5:0]  cfg_len = 6'd0;
    logic        out_valid;
    logic [31:0] out_data;
    logic [7:0]  out_status;
    logic [2:0]  fifo_level;

    int          n_checks = 0, n_fail = 0;
    logic [31:0] got_data [$];
    logic [7:0]  got_stat [$];
    logic [31:0] exp_data [$];
    logic [7:0]  exp_stat [$];
    bit          rand_ready = 1'b0;

    typedef struct {
        int          len;
        int          pce;
        int          nbits;
        logic [63:0] bits;
        logic [31:0] edata;
        logic [7:0]  estat;
    } vec_t;
    vec_t vecs [8];

    sl_receiver_fifo #(.MAX_LEN(MAX_LEN), .DEPTH(DEPTH), .LEVEL_TO(LEVEL_TO)) dut (
        .clk(clk), .rst(rst),
        .serial_line_zeroes_a(zl), .serial_line_ones_a(ol),
        .cfg_wr(cfg_wr), .cfg_len(cfg_len), .cfg_pce(cfg_pce),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_status(out_status), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Scoreboard capture: a handshake seen here completes on the next rising edge
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_stat.push_back(out_status);
        end
    end

    always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level reference: what one received frame must look like in the FIFO
    function automatic void model(input int len, input int pce, input int nbits, input logic [63:0] bits,
                                  output logic [31:0] d, output logic [7:0] st);
        int  ones = 0;
        bit  lenerr, perr;
        d = 32'h0;
        for (int i = 0; i < nbits; i++) begin
            if (i < len) d[i] = bits[i];
            if (i < len + pce && bits[i]) ones++;
        end
        lenerr = (nbits != len + pce);
        perr   = (pce != 0) && !lenerr && ((ones % 2) == 0);
        st = 8'h08 | {7'b0, lenerr} | {3'b0, perr, 4'b0};
    endfunction

    task automatic set_cfg(input int len, input int pce);
        cfg_len = 6'(len);
        cfg_pce = (pce != 0);
        cfg_wr  = 1'b1;
        @(negedge clk);
        cfg_wr  = 1'b0;
    endtask

    // kind: 0 = zeroes line, 1 = ones line, 2 = both (stop)
    task automatic sym_low(input int kind);
        if (kind != 1) zl = 1'b0;
        if (kind != 0) ol = 1'b0;
        repeat (3) @(negedge clk);
        zl = 1'b1;
        ol = 1'b1;
    endtask

    task automatic send_sym(input int kind);
        sym_low(kind);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) send_sym(v[i] ? 1 : 0);
    endtask

    task automatic send_stop_lat(output int lat);
        sym_low(2);
        lat = 0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = c;
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_n(input int n, input string name);
        int c = 0;
        while (got_data.size() < n && c < 4000) begin
            @(negedge clk);
            c++;
        end
        repeat (8) @(negedge clk);
        check(name, 64'(got_data.size()), 64'(n));
    endtask

    task automatic clear_q();
        got_data.delete();
        got_stat.delete();
    endtask

    initial begin
        int          lat;
        logic [7:0]  ov [7];
        logic [63:0] a, b, c;
        logic [31:0] md;
        logic [7:0]  ms;

        vecs[0] = '{8,  0, 8,  64'hA5,          32'hA5,       8'h08};
        vecs[1] = '{32, 1, 33, 64'h1_DEADBEEF,  32'hDEADBEEF, 8'h08};
        vecs[2] = '{32, 1, 33, 64'h0_DEADBEEF,  32'hDEADBEEF, 8'h18};
        vecs[3] = '{8,  0, 10, 64'h2C3,         32'hC3,       8'h09};
        vecs[4] = '{8,  0, 6,  64'h2A,          32'h2A,       8'h09};
        vecs[5] = '{8,  0, 8,  64'h5A,          32'h5A,       8'h08};
        vecs[6] = '{8,  1, 0,  64'h0,           32'h0,        8'h09};
        vecs[7] = '{8,  1, 9,  64'h1FF,         32'hFF,       8'h08};

        repeat (3) @(negedge clk);
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_status", 64'(out_status), 64'h0);
        check("rst_level", 64'(fifo_level), 64'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Vector table: one frame per record
        for (int r = 0; r < 8; r++) begin
            clear_q();
            set_cfg(vecs[r].len, vecs[r].pce);
            send_bits(vecs[r].bits, vecs[r].nbits);
            send_stop_lat(lat);
            check($sformatf("vec%0d_latency", r), 64'(lat), 64'd4);
            wait_n(1, $sformatf("vec%0d_count", r));
            if (got_data.size() > 0) begin
                check($sformatf("vec%0d_data", r), 64'(got_data[0]), 64'(vecs[r].edata));
                check($sformatf("vec%0d_status", r), 64'(got_stat[0]), 64'(vecs[r].estat));
            end
        end

        // Level error mid-frame, then a clean frame
        clear_q();
        set_cfg(8, 0);
        send_bits(64'h5, 3);
        zl = 1'b0;
        repeat (LEVEL_TO + 50) @(negedge clk);
        zl = 1'b1;
        repeat (4) @(negedge clk);
        send_bits(64'h3C, 8);
        send_sym(2);
        wait_n(2, "lvl_count");
        if (got_data.size() >= 2) begin
            check("lvl_status", 64'(got_stat[0]), 64'h20);
            check("lvl_data", 64'(got_data[0]), 64'h5);
            check("lvl_next_status", 64'(got_stat[1]), 64'h08);
            check("lvl_next_data", 64'(got_data[1]), 64'h3C);
        end

        // Overflow: six frames into a stalled four-entry FIFO
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) ov[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            send_bits(64'(ov[i]), 8);
            send_sym(2);
        end
        repeat (10) @(negedge clk);
        check("ovf_level", 64'(fifo_level), 64'd4);
        check("ovf_head_data", 64'(out_data), 64'(ov[0]));
        check("ovf_head_status", 64'(out_status), 64'h08);
        out_ready = 1'b1;
        wait_n(4, "ovf_drain_count");
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            check($sformatf("ovf_data%0d", i), 64'(got_data[i]), 64'(ov[i]));
            check($sformatf("ovf_status%0d", i), 64'(got_stat[i]), 64'h08);
        end
        check("ovf_empty", 64'(fifo_level), 64'd0);
        clear_q();
        send_bits(64'(ov[6]), 8);
        send_sym(2);
        wait_n(1, "ovf_next_count");
        if (got_data.size() > 0) begin
            check("ovf_next_status", 64'(got_stat[0]), 64'h48);
            check("ovf_next_data", 64'(got_data[0]), 64'(ov[6]));
        end

        // Config write mid-frame, then reset mid-frame
        clear_q();
        a = 64'($urandom_range(0, 255));
        set_cfg(8, 0);
        send_bits(a, 2);
        set_cfg(16, 0);
        send_bits(a >> 2, 6);
        send_sym(2);
        wait_n(1, "cfg_count");
        if (got_data.size() > 0) begin
            check("cfg_status", 64'(got_stat[0]), 64'h08);
            check("cfg_data", 64'(got_data[0]), a);
        end
        clear_q();
        out_ready = 1'b0;
        b = 64'($urandom_range(0, 65535));
        send_bits(b, 16);
        send_sym(2);
        repeat (10) @(negedge clk);
        check("cfg16_level", 64'(fifo_level), 64'd1);
        check("cfg16_status", 64'(out_status), 64'h08);
        send_bits(64'h7, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("srst_valid", 64'(out_valid), 64'h0);
        check("srst_level", 64'(fifo_level), 64'h0);
        out_ready = 1'b1;
        c = 64'($urandom);
        send_bits(c, 32);
        send_sym(2);
        wait_n(1, "srst_next_count");
        if (got_data.size() > 0) begin
            check("srst_next_status", 64'(got_stat[0]), 64'h08);
            check("srst_next_data", 64'(got_data[0]), c);
        end

        // Randomized frames with random back-pressure
        clear_q();
        rand_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int          len, pce, nb;
            logic [63:0] bits;
            len = $urandom_range(1, MAX_LEN);
            pce = $urandom_range(0, 1);
            nb  = ($urandom_range(0, 9) < 7) ? len + pce : $urandom_range(0, MAX_LEN + 2);
            bits = {$urandom, $urandom};
            set_cfg(len, pce);
            send_bits(bits, nb);
            send_sym(2);
            model(len, pce, nb, bits, md, ms);
            exp_data.push_back(md);
            exp_stat.push_back(ms);
        end
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        wait_n(20, "rand_count");
        for (int i = 0; i < 20 && i < got_data.size(); i++) begin
            check($sformatf("rand%0d_data", i), 64'(got_data[i]), 64'(exp_data[i]));
            check($sformatf("rand%0d_status", i), 64'(got_stat[i]), 64'(exp_stat[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sl_receiver_fifo.md
# sl_receiver_fifo

Parametrised successor to the single-word SL receiver. It decodes two-wire SL frames (zeroes line, ones line) of configurable length up to `MAX_LEN` bits, with optional odd parity, length checking and level-error detection. Each completed or aborted frame becomes one data-plus-status entry in a `DEPTH`-entry receive FIFO. The FIFO drains over a valid/ready port, so frames are no longer lost when the host reads late.

## Interface
Parameters:
- `MAX_LEN`, 32: maximum data bits per frame (2..64).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `LEVEL_TO`, 1024: maximum cycles any line may stay low before a level error.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `serial_line_zeroes_a` in 1: async SL zeroes line, idle high.
- `serial_line_ones_a` in 1: async SL ones line, idle high.
- `cfg_wr` in 1: one-cycle strobe that loads `cfg_len` and `cfg_pce` into the shadow config.
- `cfg_len` in `$clog2(MAX_LEN+1)`: expected data bits (1..`MAX_LEN`).
- `cfg_pce` in 1: parity check enable.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer accepts head.
- `out_data` out `MAX_LEN`: received bits, first bit in bit 0, zero-extended.
- `out_status` out 8: [0] length error, [3] frame done, [4] parity error, [5] level error, [6] overflow (≥1 earlier frame dropped), others 0.
- `fifo_level` out `$clog2(DEPTH+1)`: entries held.

## Operation
- Both lines pass through 2-flop synchronisers; optional glitch filter (see Configuration).
- Symbol: starts when either line goes low, ends when both are high again. Track a low-mask over the symbol and decode at symbol end:
  - zeroes only → data 0
  - ones only → data 1
  - both → stop
- Frame: `cfg_len` data symbols, then one parity symbol (an ordinary 0/1 symbol) if PCE, then stop.
- Parity is odd: data ones plus the parity bit must total an odd count.
- Active config (len, pce) is copied from shadow at the first symbol of a frame; `cfg_wr` mid-frame affects only the next frame.
- States:
  - IDLE (no symbols).
  - RX (counting symbols). Data bits shift into position `count`. Bits beyond `cfg_len` (+1 if PCE) are discarded; the count saturates at `MAX_LEN+2`.
  - ABORT (after level error; waits for both lines high → IDLE, pushes nothing further).
- On stop in RX, push one entry:
  - bit3 = 1.
  - bit0 = (symbol count ≠ `cfg_len` + pce).
  - bit4 = pce & !bit0 & parity wrong.
  - data = bits received, LSB first.
  - A stop in IDLE pushes status 0x09 with data 0.
- Level error: low-time counter runs while either line is low and clears when both are high. Reaching `LEVEL_TO` pushes {status 0x20, partial data}, enters ABORT, and fires once per low episode (also from IDLE).
- FIFO:
  - Push when full drops the entry and sets a sticky `ovf`. `ovf` is ORed into bit6 of the next successfully pushed entry, then cleared.
  - Push and pop in the same cycle while full is a normal pop plus push, with no drop.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_status` = 0, `fifo_level` = 0.
  - Shadow config = {`MAX_LEN`, 0}, state IDLE, counters 0, `ovf` = 0.
- Reset mid-frame discards the frame and all FIFO contents.
- Latency without filter:
  - Stop symbol: last line high at pin → `out_valid` high 4 cycles later (2 sync, 1 decode/push, 1 FIFO register).
  - Level error: flagged on the `LEVEL_TO`-th consecutive synced low cycle; entry visible 2 cycles later.
- Handshake:
  - Pop on `out_valid & out_ready`.
  - `out_data` and `out_status` are stable while `out_valid & !out_ready`.
  - `out_valid` is independent of `out_ready`.
- Minimum line pulse and minimum high gap: 2 cycles without filter, 4 with filter.
- Pointers wrap modulo `DEPTH`; full when `fifo_level == DEPTH`.

## Configuration
- `SL_RX_GLITCH_FILTER_EN` defined:
  - Each synced line changes state only after 3 consecutive equal samples.
  - Glitches of 1–2 cycles are ignored.
  - All pin-referenced latencies grow by 2 cycles.
- Undefined: synced lines are used directly.

## Test plan
- `cfg_len`=8, pce=0; send 0xA5, `out_ready`=1 → one entry, data 0xA5, status 0x08, `out_valid` 4 cycles after the stop rising edge.
- `cfg_len`=32, pce=1; send 0xDEADBEEF + correct parity, then the same word with wrong parity → entries 0x08 then 0x18, both with data 0xDEADBEEF.
- `cfg_len`=8; send 10 data bits + stop, then 6 + stop, then 8 + stop → status 0x09, 0x09, 0x08.
- Hold the zeroes line low for `LEVEL_TO`+50 cycles mid-frame, release, send a valid 8-bit frame → entries 0x20, then 0x08 with the correct data; only one level-error entry.
- `DEPTH`=4, `out_ready`=0; send 6 valid frames, then raise `out_ready` → first 4 entries unchanged, `fifo_level` saturates at 4; the 7th frame sent after draining has status 0x48.
- `cfg_wr` changing len 8→16 during a frame, then assert `rst` for 1 cycle mid-frame → in-flight frame decoded with len 8; after reset `out_valid`=0, `fifo_level`=0, and the next frame uses shadow len `MAX_LEN`.
